// File: rtl/or_gate_if.sv
// Signal bundle for the or_gate primitive: the two operands, the combinational
// result, the synchronous clear and the registered monitor outputs.
// The driver of the operands uses the master view; the gate itself uses the slave view.
interface or_gate_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Y;
    logic             clr;
    logic [WIDTH-1:0] y_q;
    logic             y_any;
    logic [WIDTH-1:0] sticky;
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        output A,
        output B,
        output clr,
        input  Y,
        input  y_q,
        input  y_any,
        input  sticky,
        input  hit_cnt
    );

    modport slave (
        input  A,
        input  B,
        input  clr,
        output Y,
        output y_q,
        output y_any,
        output sticky,
        output hit_cnt
    );
endinterface

// File: rtl/or_gate.sv
// Bitwise OR glue primitive with a lightweight activity monitor.
// Y is purely combinational. Alongside it, the monitor keeps:
//  - a registered copy of Y
//  - a registered "any bit set" flag
//  - a sticky per-bit accumulator
//  - a saturating count of the edges at which any bit of Y was set
// A synchronous clear wipes the accumulator and the counter, but the sample
// taken on that same edge is still accumulated and counted.
module or_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    or_gate_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] y_comb;
    logic             hit;
    logic [CNT_W-1:0] hit_inc;
    logic [WIDTH-1:0] y_q_r;
    logic             y_any_r;
    logic [WIDTH-1:0] sticky_r;
    logic [CNT_W-1:0] hit_cnt_r;

    assign y_comb  = bus.A | bus.B;
    assign hit     = |y_comb;
    assign hit_inc = CNT_W'(hit);

    assign bus.Y       = y_comb;
    assign bus.y_q     = y_q_r;
    assign bus.y_any   = y_any_r;
    assign bus.sticky  = sticky_r;
    assign bus.hit_cnt = hit_cnt_r;

    // Monitor registers: sample Y, accumulate it, and count active edges without wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q_r     <= '0;
            y_any_r   <= 1'b0;
            sticky_r  <= '0;
            hit_cnt_r <= '0;
        end else begin
            y_q_r   <= y_comb;
            y_any_r <= hit;
            if (bus.clr) begin
                sticky_r  <= y_comb;
                hit_cnt_r <= hit_inc;
            end else begin
                sticky_r <= sticky_r | y_comb;
                if (hit_cnt_r == CNT_MAX) begin
                    hit_cnt_r <= CNT_MAX;
                end else begin
                    hit_cnt_r <= hit_cnt_r + hit_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_or_gate.sv
// Directed bench for or_gate. Three instances share clock and reset:
//  dut1    WIDTH=1, CNT_W=8  truth table, clear behaviour, asynchronous reset
//  dut4    WIDTH=4, CNT_W=8  per-bit accumulation
//  dut_sat WIDTH=1, CNT_W=2  counter saturation
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or a few time units away from any rising edge.
module tb_or_gate;

    logic clk;
    logic rst;

    int total;
    int passed;

    or_gate_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
    or_gate_if #(.WIDTH(4), .CNT_W(8)) bus4 ();
    or_gate_if #(.WIDTH(1), .CNT_W(2)) bus_sat ();

    or_gate #(.WIDTH(1), .CNT_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    or_gate #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    or_gate #(.WIDTH(1), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and report tag/observed/expected on mismatch
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic next_fall();
        @(negedge clk);
    endtask

    initial begin
        total  = 0;
        passed = 0;

        rst         = 1'b1;
        bus1.A      = 1'b0;
        bus1.B      = 1'b0;
        bus1.clr    = 1'b0;
        bus4.A      = 4'b0000;
        bus4.B      = 4'b0000;
        bus4.clr    = 1'b0;
        bus_sat.A   = 1'b0;
        bus_sat.B   = 1'b0;
        bus_sat.clr = 1'b0;

        next_fall();
        next_fall();
        check_output("reset_y_q",     32'(bus1.y_q),     32'h0);
        check_output("reset_y_any",   32'(bus1.y_any),   32'h0);
        check_output("reset_sticky",  32'(bus1.sticky),  32'h0);
        check_output("reset_hit_cnt", 32'(bus1.hit_cnt), 32'h0);

        // Truth table while the registers are held in reset
        bus1.A = 1'b0; bus1.B = 1'b0; #1;
        check_output("tt_00", 32'(bus1.Y), 32'h0);
        #9;
        bus1.A = 1'b0; bus1.B = 1'b1; #1;
        check_output("tt_01", 32'(bus1.Y), 32'h1);
        #9;
        bus1.A = 1'b1; bus1.B = 1'b0; #1;
        check_output("tt_10", 32'(bus1.Y), 32'h1);
        #9;
        bus1.A = 1'b1; bus1.B = 1'b1; #1;
        check_output("tt_11", 32'(bus1.Y), 32'h1);
        check_output("tt_y_q_held_in_reset", 32'(bus1.y_q), 32'h0);

        // Release reset with dut1 driving a steady 1 so its registers fill
        next_fall();
        bus1.A = 1'b1;
        bus1.B = 1'b0;
        rst    = 1'b0;

        // Per-bit accumulation on the 4-bit instance
        next_fall();
        bus4.A = 4'b0001; bus4.B = 4'b0000;
        next_fall();
        check_output("w4_y_q_1",    32'(bus4.y_q),     32'h1);
        check_output("w4_sticky_1", 32'(bus4.sticky),  32'h1);
        check_output("w4_hit_1",    32'(bus4.hit_cnt), 32'd1);
        bus4.A = 4'b0000; bus4.B = 4'b0100;
        next_fall();
        check_output("w4_y_q_2",    32'(bus4.y_q),     32'h4);
        check_output("w4_sticky_2", 32'(bus4.sticky),  32'h5);
        check_output("w4_hit_2",    32'(bus4.hit_cnt), 32'd2);
        check_output("w4_any_2",    32'(bus4.y_any),   32'h1);
        bus4.A = 4'b0000; bus4.B = 4'b0000;
        next_fall();
        check_output("w4_y_q_3",    32'(bus4.y_q),     32'h0);
        check_output("w4_any_3",    32'(bus4.y_any),   32'h0);
        check_output("w4_sticky_3", 32'(bus4.sticky),  32'h5);
        check_output("w4_hit_3",    32'(bus4.hit_cnt), 32'd2);

        // Clear and active sample on the same edge: clear first, then count
        check_output("pre_clr_hit", 32'(bus1.hit_cnt), 32'd4);
        bus1.clr = 1'b1;
        next_fall();
        check_output("clr_sticky", 32'(bus1.sticky),  32'h1);
        check_output("clr_hit",    32'(bus1.hit_cnt), 32'd1);
        check_output("clr_any",    32'(bus1.y_any),   32'h1);
        bus1.clr = 1'b0;
        bus1.A   = 1'b0;
        next_fall();
        check_output("idle_sticky", 32'(bus1.sticky),  32'h1);
        check_output("idle_hit",    32'(bus1.hit_cnt), 32'd1);
        check_output("idle_y_q",    32'(bus1.y_q),     32'h0);
        bus1.A = 1'b1;
        next_fall();
        check_output("busy_hit", 32'(bus1.hit_cnt), 32'd2);
        check_output("busy_y_q", 32'(bus1.y_q),     32'h1);

        // Asynchronous reset mid-operation, away from any rising edge
        #2;
        rst = 1'b1;
        #1;
        check_output("arst_y_q",     32'(bus1.y_q),     32'h0);
        check_output("arst_y_any",   32'(bus1.y_any),   32'h0);
        check_output("arst_sticky",  32'(bus1.sticky),  32'h0);
        check_output("arst_hit_cnt", 32'(bus1.hit_cnt), 32'h0);
        check_output("arst_w4_sticky", 32'(bus4.sticky), 32'h0);
        check_output("arst_y_live",  32'(bus1.Y),       32'h1);
        bus1.A = 1'b0; bus1.B = 1'b1; #1;
        check_output("arst_y_01", 32'(bus1.Y), 32'h1);
        bus1.A = 1'b0; bus1.B = 1'b0; #1;
        check_output("arst_y_00", 32'(bus1.Y), 32'h0);
        next_fall();
        check_output("arst_hold_hit", 32'(bus1.hit_cnt), 32'h0);

        // Saturation of the 2-bit counter
        rst       = 1'b0;
        bus_sat.A = 1'b1;
        next_fall();
        check_output("sat_1", 32'(bus_sat.hit_cnt), 32'd1);
        next_fall();
        check_output("sat_2", 32'(bus_sat.hit_cnt), 32'd2);
        next_fall();
        check_output("sat_3", 32'(bus_sat.hit_cnt), 32'd3);
        next_fall();
        check_output("sat_4", 32'(bus_sat.hit_cnt), 32'd3);
        next_fall();
        check_output("sat_5", 32'(bus_sat.hit_cnt), 32'd3);
        next_fall();
        check_output("sat_6", 32'(bus_sat.hit_cnt), 32'd3);
        bus_sat.A   = 1'b0;
        bus_sat.clr = 1'b1;
        next_fall();
        check_output("sat_clr_idle", 32'(bus_sat.hit_cnt), 32'd0);
        check_output("sat_clr_sticky", 32'(bus_sat.sticky), 32'h0);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
